// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter for two byte requesters feeding one 8N1/8N2 UART
// transmitter paced by an external baud tick.
module uart_tx_scheduler #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_50m,
    input  logic       reset,
    input  logic       Txclk_en,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t     state;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic       last;
    logic [1:0] pick;
    logic [1:0] take;

    // With both requesters valid, the one not granted last time wins.
    always_comb begin
        pick = 2'b00;
        if (req_valid == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end else if (req_valid[0]) begin
            pick = 2'b01;
        end else if (req_valid[1]) begin
            pick = 2'b10;
        end
    end

    assign take = req_valid & req_ready;

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            last      <= 1'b1;
            req_ready <= 2'b00;
            tx        <= 1'b1;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
        end else begin
            req_ready <= 2'b00;
            unique case (state)
                IDLE: begin
                    // Ready is offered for one cycle; a withdrawn request
                    // simply falls back to arbitration.
                    if (take != 2'b00) begin
                        shift    <= take[1] ? req_data1 : req_data0;
                        grant_id <= take[1];
                        last     <= take[1];
                        busy     <= 1'b1;
                        state    <= START;
                    end else if (req_ready == 2'b00) begin
                        req_ready <= pick;
                    end
                end
                START: begin
                    if (Txclk_en) begin
                        tx      <= 1'b0;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (Txclk_en) begin
                        tx    <= shift[0];
                        shift <= {1'b0, shift[7:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (Txclk_en) begin
                        tx <= 1'b1;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: tick-sampled frames, arbitration,
// reset abort, accept-cycle tick and two-stop-bit spacing.
module tb_uart_tx_scheduler;

    logic       clk_50m = 1'b0;
    logic       reset;
    logic       Txclk_en;
    logic [1:0] req_valid, req_valid_b;
    logic [7:0] req_data0, req_data1, req_data0_b, req_data1_b;
    logic [1:0] req_ready, req_ready_b;
    logic       tx, busy, grant_id;
    logic       tx_b, busy_b, grant_id_b;

    int vectors = 0;
    int errors = 0;
    int phase = 0;
    int pulses = 0;
    int nticks_a = 0;
    logic [9:0] frame_a = '0;

    uart_tx_scheduler #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk_50m(clk_50m), .reset(reset), .Txclk_en(Txclk_en),
        .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_scheduler #(.DATA_BITS(8), .STOP_BITS(2)) dut_b (
        .clk_50m(clk_50m), .reset(reset), .Txclk_en(Txclk_en),
        .req_valid(req_valid_b), .req_data0(req_data0_b),
        .req_data1(req_data1_b), .req_ready(req_ready_b), .tx(tx_b),
        .busy(busy_b), .grant_id(grant_id_b)
    );

    always #5 clk_50m = ~clk_50m;

    // Line value just after every tick that lands inside a frame.
    always @(posedge clk_50m) begin
        if (Txclk_en && busy) begin
            #1;
            frame_a = {frame_a[8:0], tx};
            nticks_a++;
        end
    end

    always @(negedge clk_50m) begin
        if (!reset) begin
            if (req_ready == 2'b11) begin
                errors++;
                $display("FAIL ready_onehot: got %b required not 11", req_ready);
            end
            if (busy && req_ready != 2'b00) begin
                errors++;
                $display("FAIL ready_in_frame: got %b required 00", req_ready);
            end
            if (req_ready != 2'b00) pulses++;
        end
    end

    typedef struct {
        logic       do_rst;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ready;
        logic       exp_gid;
        logic [9:0] exp_bits;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_50m);
        Txclk_en = (phase == 0);
        phase = (phase + 1) % 8;
    endtask

    task automatic apply_reset();
        @(negedge clk_50m);
        reset = 1'b1;
        req_valid = 2'b00;
        req_valid_b = 2'b00;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 64 && req_ready == 2'b00; n++) cyc();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && busy; n++) cyc();
    endtask

    task automatic do_frame(input string nm, input logic [1:0] v,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [1:0] er, input logic eg,
                            input logic [9:0] eb);
        logic [1:0] seen;
        int base;
        req_data0 = d0;
        req_data1 = d1;
        req_valid = v;
        base = nticks_a;
        wait_ready();
        seen = req_ready;
        chk({nm, "_ready"}, 32'(seen), 32'(er));
        cyc();
        req_valid = req_valid & ~seen;
        wait_idle();
        chk({nm, "_bits"}, 32'(frame_a), 32'(eb));
        chk({nm, "_ticks"}, nticks_a - base, 10);
        chk({nm, "_gid"}, 32'(grant_id), 32'(eg));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] order[4];
        logic [1:0] seen;
        logic       ok;
        int base, lo, hi, lo2;

        vecs[0] = '{1'b1, 2'b01, 8'hA5, 8'h00, 2'b01, 1'b0, 10'b0101001011};
        vecs[1] = '{1'b1, 2'b11, 8'h55, 8'h0F, 2'b01, 1'b0, 10'b0101010101};
        vecs[2] = '{1'b0, 2'b10, 8'h55, 8'h0F, 2'b10, 1'b1, 10'b0111100001};
        vecs[3] = '{1'b0, 2'b10, 8'h00, 8'h3C, 2'b10, 1'b1, 10'b0001111001};
        vecs[4] = '{1'b0, 2'b11, 8'h81, 8'h00, 2'b01, 1'b0, 10'b0100000011};
        vecs[5] = '{1'b0, 2'b10, 8'h81, 8'h00, 2'b10, 1'b1, 10'b0000000001};

        reset = 1'b1;
        Txclk_en = 1'b0;
        req_valid = 2'b00;
        req_valid_b = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        req_data0_b = '0;
        req_data1_b = '0;
        cyc();
        cyc();
        chk("reset_a", 32'({tx, busy, req_ready, grant_id}), 32'b10000);
        chk("reset_b", 32'({tx_b, busy_b, req_ready_b, grant_id_b}), 32'b10000);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_rst) apply_reset();
            do_frame($sformatf("vec%0d", i), vecs[i].valid, vecs[i].d0,
                     vecs[i].d1, vecs[i].exp_ready, vecs[i].exp_gid,
                     vecs[i].exp_bits);
        end

        // Tick landing on the accept edge must not start the frame.
        req_data0 = 8'hC3;
        req_valid = 2'b01;
        base = nticks_a;
        wait_ready();
        chk("acc_ready", 32'(req_ready), 32'b01);
        Txclk_en = 1'b1;
        phase = 1;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            req_valid = 2'b00;
            if (tx !== 1'b1) ok = 1'b0;
        end
        chk("acc_tx_held", 32'(ok), 32'd1);
        cyc();
        chk("acc_start", 32'(tx), 32'd0);
        wait_idle();
        chk("acc_bits", 32'(frame_a), 32'(10'b0110000111));
        chk("acc_ticks", nticks_a - base, 10);

        // Reset in the middle of the data bits.
        req_data0 = 8'hA5;
        req_valid = 2'b01;
        base = nticks_a;
        wait_ready();
        cyc();
        req_valid = 2'b00;
        for (int n = 0; n < 100 && nticks_a - base < 4; n++) cyc();
        reset = 1'b1;
        #1;
        chk("rst_mid", 32'({tx, busy, req_ready}), 32'b1000);
        cyc();
        reset = 1'b0;
        do_frame("rst_req1", 2'b10, 8'h00, 8'h0F, 2'b10, 1'b1,
                 10'b0111100001);

        // Continuous load from both requesters.
        apply_reset();
        req_data0 = 8'h11;
        req_data1 = 8'h22;
        req_valid = 2'b11;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready();
            order[k] = req_ready;
            cyc();
            if (k == 3) req_valid = 2'b00;
            wait_idle();
        end
        chk("rr_0", 32'(order[0]), 32'b01);
        chk("rr_1", 32'(order[1]), 32'b10);
        chk("rr_2", 32'(order[2]), 32'b01);
        chk("rr_3", 32'(order[3]), 32'b10);
        chk("rr_pulses", pulses, 4);

        // Two stop bits between back-to-back frames.
        apply_reset();
        req_data0_b = 8'h00;
        req_data1_b = 8'h00;
        req_valid_b = 2'b01;
        for (int n = 0; n < 64 && req_ready_b == 2'b00; n++) cyc();
        cyc();
        req_valid_b = 2'b10;
        for (int n = 0; n < 100 && tx_b; n++) cyc();
        lo = 0;
        while (tx_b == 1'b0 && lo < 200) begin
            cyc();
            lo++;
        end
        hi = 0;
        while (tx_b == 1'b1 && hi < 200) begin
            seen = req_ready_b;
            cyc();
            hi++;
            req_valid_b = req_valid_b & ~seen;
        end
        lo2 = 0;
        while (tx_b == 1'b0 && lo2 < 200) begin
            cyc();
            lo2++;
        end
        chk("stop2_low1", lo, 72);
        chk("stop2_gap", hi, 16);
        chk("stop2_low2", lo2, 72);
        for (int n = 0; n < 200 && busy_b; n++) cyc();
        chk("stop2_gid", 32'({busy_b, grant_id_b}), 32'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
